// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALUOp, opcode/funct encodings and sequencer types
package alu_pkg;

    localparam int OP_W    = 6;
    localparam int ALUOP_W = 4;

    localparam logic [3:0] ALUOP_NO_OP     = 4'h0;
    localparam logic [3:0] ALUOP_ADD       = 4'h1;
    localparam logic [3:0] ALUOP_SUB       = 4'h2;
    localparam logic [3:0] ALUOP_AND       = 4'h3;
    localparam logic [3:0] ALUOP_PASS_B    = 4'h4;
    localparam logic [3:0] ALUOP_SHIFT_L1  = 4'h5;
    localparam logic [3:0] ALUOP_SHIFT_L2  = 4'h6;
    localparam logic [3:0] ALUOP_SHIFT_R   = 4'h7;
    localparam logic [3:0] ALUOP_SHIFT_RA1 = 4'h8;
    localparam logic [3:0] ALUOP_SHIFT_RA2 = 4'h9;
    localparam logic [3:0] ALUOP_SLTI      = 4'hA;
    localparam logic [3:0] ALUOP_BEQ       = 4'hB;
    localparam logic [3:0] ALUOP_BNE       = 4'hC;
    localparam logic [3:0] ALUOP_BLE       = 4'hD;
    localparam logic [3:0] ALUOP_BGT       = 4'hE;
    localparam logic [3:0] ALUOP_LUI       = 4'hF;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_BLE   = 6'h06;
    localparam logic [5:0] OPC_BGT   = 6'h07;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_SRA = 6'h03;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;

    typedef enum logic [1:0] {
        SEQ_LEN_0 = 2'd0,
        SEQ_LEN_1 = 2'd1,
        SEQ_LEN_2 = 2'd2
    } seq_len_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP1 = 2'd1,
        ST_STEP2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        seq_len_t   len;
        logic [3:0] step1;
        logic [3:0] step2;
        logic       load1;
        logic       load2;
        logic       illegal;
    } seq_t;

    function automatic seq_t one_step(input logic [3:0] code);
        seq_t s;
        s.len     = SEQ_LEN_1;
        s.step1   = code;
        s.step2   = ALUOP_NO_OP;
        s.load1   = 1'b1;
        s.load2   = 1'b0;
        s.illegal = 1'b0;
        return s;
    endfunction

    function automatic seq_t two_step(input logic [3:0] code1, input logic [3:0] code2,
                                      input logic load2);
        seq_t s;
        s.len     = SEQ_LEN_2;
        s.step1   = code1;
        s.step2   = code2;
        s.load1   = 1'b1;
        s.load2   = load2;
        s.illegal = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - start/ready request bus and ALUOp output bundle
interface alu_op_sequencer_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
) ();
    logic               start;
    logic [OP_W-1:0]    opcode;
    logic [OP_W-1:0]    funct;
    logic               ready;
    logic [ALUOP_W-1:0] alu_op;
    logic               aluout_load;
    logic               done;
    logic               illegal;

    modport master (
        output start, opcode, funct,
        input  ready, alu_op, aluout_load, done, illegal
    );

    modport slave (
        input  start, opcode, funct,
        output ready, alu_op, aluout_load, done, illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode/funct to ALUOp step sequence mapping
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] opcode_i,
    input  logic [OP_W-1:0] funct_i,
    output seq_t            seq_o
);

    always_comb begin
        seq_o.len     = SEQ_LEN_0;
        seq_o.step1   = ALUOP_NO_OP;
        seq_o.step2   = ALUOP_NO_OP;
        seq_o.load1   = 1'b0;
        seq_o.load2   = 1'b0;
        seq_o.illegal = 1'b1;
        case (opcode_i)
            OPC_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: seq_o = one_step(ALUOP_ADD);
                    FUNCT_SUB: seq_o = one_step(ALUOP_SUB);
                    FUNCT_AND: seq_o = one_step(ALUOP_AND);
                    FUNCT_SLL: seq_o = two_step(ALUOP_SHIFT_L1, ALUOP_SHIFT_L2, 1'b1);
                    FUNCT_SRL: seq_o = two_step(ALUOP_SHIFT_R, ALUOP_SHIFT_R, 1'b1);
                    FUNCT_SRA: seq_o = two_step(ALUOP_SHIFT_RA1, ALUOP_SHIFT_RA2, 1'b1);
                    default:   ;
                endcase
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: seq_o = one_step(ALUOP_ADD);
            OPC_SLTI: seq_o = one_step(ALUOP_SLTI);
            OPC_LUI:  seq_o = one_step(ALUOP_LUI);
            // Branch target is computed first; the compare step must not overwrite it
            OPC_BEQ:  seq_o = two_step(ALUOP_ADD, ALUOP_BEQ, 1'b0);
            OPC_BNE:  seq_o = two_step(ALUOP_ADD, ALUOP_BNE, 1'b0);
            OPC_BLE:  seq_o = two_step(ALUOP_ADD, ALUOP_BLE, 1'b0);
            OPC_BGT:  seq_o = two_step(ALUOP_ADD, ALUOP_BGT, 1'b0);
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multicycle execute-phase ALUOp sequencer with registered outputs
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_op_sequencer_if.slave  bus
);

    seq_t   dec_seq;
    state_t state_q, state_d;
    seq_t   seq_q, seq_d;

    logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
    logic               load_q, load_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;

    alu_op_decode #(.OP_W(OP_W)) u_decode (
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .seq_o    (dec_seq)
    );

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    seq_d   = dec_seq;
                    state_d = dec_seq.illegal ? ST_DONE : ST_STEP1;
                end
            end
            ST_STEP1: state_d = (seq_q.len == SEQ_LEN_2) ? ST_STEP2 : ST_DONE;
            ST_STEP2: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop
    always_comb begin
        alu_op_d  = ALUOP_NO_OP;
        load_d    = 1'b0;
        ready_d   = (state_d == ST_IDLE);
        done_d    = (state_d == ST_DONE);
        illegal_d = (state_d == ST_DONE) && seq_d.illegal;
        case (state_d)
            ST_STEP1: begin
                alu_op_d = seq_d.step1;
                load_d   = seq_d.load1;
            end
            ST_STEP2: begin
                alu_op_d = seq_d.step2;
                load_d   = seq_d.load2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            seq_q     <= '0;
            alu_op_q  <= ALUOP_NO_OP;
            load_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            alu_op_q  <= alu_op_d;
            load_q    <= load_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.alu_op      = alu_op_q;
    assign bus.aluout_load = load_q;
    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.OP_W(6), .ALUOP_W(4)) bus ();

    alu_op_sequencer #(.OP_W(6), .ALUOP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: step list per instruction; codes[3:0]=step1, codes[7:4]=step2
    function automatic void ref_seq(input logic [5:0] op, input logic [5:0] fn,
                                    output int n, output logic [7:0] codes,
                                    output logic [1:0] loads, output bit ill);
        logic [3:0] cmp;
        n = 0; codes = 8'h00; loads = 2'b00; ill = 1'b0;
        cmp = 4'hB + op[3:0] - 4'h4;
        if (op == 6'h00) begin
            if      (fn == 6'h20) begin n = 1; codes = 8'h01; loads = 2'b01; end
            else if (fn == 6'h22) begin n = 1; codes = 8'h02; loads = 2'b01; end
            else if (fn == 6'h24) begin n = 1; codes = 8'h03; loads = 2'b01; end
            else if (fn == 6'h00) begin n = 2; codes = 8'h65; loads = 2'b11; end
            else if (fn == 6'h02) begin n = 2; codes = 8'h77; loads = 2'b11; end
            else if (fn == 6'h03) begin n = 2; codes = 8'h98; loads = 2'b11; end
            else ill = 1'b1;
        end else if (op inside {6'h08, 6'h09, 6'h23, 6'h2B}) begin
            n = 1; codes = 8'h01; loads = 2'b01;
        end else if (op == 6'h0A) begin
            n = 1; codes = 8'h0A; loads = 2'b01;
        end else if (op == 6'h0F) begin
            n = 1; codes = 8'h0F; loads = 2'b01;
        end else if (op >= 6'h04 && op <= 6'h07) begin
            n = 2; codes = {cmp, 4'h1}; loads = 2'b01;
        end else begin
            ill = 1'b1;
        end
    endfunction

    // Issue one instruction and check every cycle until ready returns
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input bit scramble);
        int         n;
        logic [7:0] codes;
        logic [1:0] loads;
        bit         ill;
        int         waitc;
        logic [7:0] exp;
        logic [7:0] got;
        ref_seq(op, fn, n, codes, loads, ill);
        waitc = 0;
        while (bus.ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        n_tests++;
        if (bus.ready !== 1'b1) begin
            $display("FAIL %s ready_timeout got=%b want=1", name, bus.ready);
            n_fail++;
        end
        bus.start = 1'b1; bus.opcode = op; bus.funct = fn;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (scramble) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
            end
            @(negedge clk);
            exp = {codes[i*4 +: 4], loads[i], 1'b0, 1'b0, 1'b0};
            got = {bus.alu_op, bus.aluout_load, bus.ready, bus.done, bus.illegal};
            n_tests++;
            if (got !== exp) begin
                $display("FAIL %s step%0d {alu_op,load,ready,done,illegal} got=%h want=%h", name, i + 1, got, exp);
                n_fail++;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        exp = {4'h0, 1'b0, 1'b0, 1'b1, ill};
        got = {bus.alu_op, bus.aluout_load, bus.ready, bus.done, bus.illegal};
        n_tests++;
        if (got !== exp) begin
            $display("FAIL %s done_cycle {alu_op,load,ready,done,illegal} got=%h want=%h", name, got, exp);
            n_fail++;
        end
        @(negedge clk);
        exp = {4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        got = {bus.alu_op, bus.aluout_load, bus.ready, bus.done, bus.illegal};
        n_tests++;
        if (got !== exp) begin
            $display("FAIL %s back_to_idle {alu_op,load,ready,done,illegal} got=%h want=%h", name, got, exp);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset = 1'b0; bus.start = 1'b1; bus.opcode = 6'h08; bus.funct = 6'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {bus.alu_op, bus.aluout_load, bus.ready, bus.done, bus.illegal};
            n_tests++;
            if (got !== 8'h04) begin
                $display("FAIL reset_cycle%0d {alu_op,load,ready,done,illegal} got=%h want=04", i, got);
                n_fail++;
            end
        end
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addi();
        run_instr("addi", 6'h08, 6'($urandom), 1'b0);
    endtask

    task automatic test_sra();
        run_instr("sra", 6'h00, 6'h03, 1'b1);
    endtask

    task automatic test_bgt();
        run_instr("bgt", 6'h07, 6'($urandom), 1'b1);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 6'h3F, 6'h00, 1'b0);
        run_instr("illegal_funct", 6'h00, 6'h21, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] got;
        run_instr("pre_beq_idle", 6'h0F, 6'h00, 1'b0);
        bus.start = 1'b1; bus.opcode = 6'h04; bus.funct = 6'h00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.alu_op !== 4'hB) begin
            $display("FAIL rst_mid beq_step2 alu_op got=%h want=b", bus.alu_op);
            n_fail++;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        got = {bus.alu_op, bus.aluout_load, bus.ready, bus.done, bus.illegal};
        n_tests++;
        if (got !== 8'h04) begin
            $display("FAIL rst_mid idle {alu_op,load,ready,done,illegal} got=%h want=04", got);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.done !== 1'b0) begin
                $display("FAIL rst_mid no_done cycle%0d got=%b want=0", i, bus.done);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got;
        logic [4:0] exp;
        bus.start = 1'b1; bus.opcode = 6'h08; bus.funct = 6'h00;
        // start held high: accept, step, done, accept again on the idle cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp = {((i % 3) == 0) ? 4'h1 : 4'h0, (i % 3) == 1};
            got = {bus.alu_op, bus.done};
            n_tests++;
            if (got !== exp) begin
                $display("FAIL back_to_back cycle%0d {alu_op,done} got=%h want=%h", i, got, exp);
                n_fail++;
            end
        end
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0] ops [12];
        logic [5:0] fns [8];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0F, 6'h23, 6'h2B};
        fns = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h24, 6'h21, 6'h3F};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 11)];
            fn = fns[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            run_instr("random", op, fn, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.opcode = 6'h00; bus.funct = 6'h00;
        reset = 1'b0;
        test_reset();
        test_addi();
        test_sra();
        test_bgt();
        test_illegal();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multicycle execute-phase sequencer that sits directly upstream of the ALU control decoder. It accepts a decoded instruction (opcode/funct) from the main control unit through a start/ready handshake. It then issues the 4-bit ALUOp code sequence that instruction needs, one code per cycle, and reports completion with a one-cycle `done` pulse. Shifts and branches take two ALUOp steps; all other supported instructions take one.

## Interface
Parameters:
- `OP_W`, 6: opcode and funct field width.
- `ALUOP_W`, 4: ALUOp code width; fixed by the ALU control decoder encoding.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `start`  in  1  request; accepted only when `ready`=1.
- `opcode`  in  OP_W  instruction opcode; sampled only on the accepting edge.
- `funct`  in  OP_W  R-type funct; sampled only on the accepting edge.
- `ready`  out  1  sequencer idle, can accept `start`.
- `alu_op`  out  ALUOP_W  registered ALUOp code to the ALU control decoder.
- `aluout_load`  out  1  ALUOut register write enable for the current step.
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for an unsupported opcode/funct.

## Operation
- ALUOp codes: NO_OP 0000, ADD 0001, SUB 0010, AND 0011, PASS_B 0100, SHIFT_L1 0101, SHIFT_L2 0110, SHIFT_R 0111, SHIFT_RA1 1000, SHIFT_RA2 1001, SLTI 1010, BEQ 1011, BNE 1100, BLE 1101, BGT 1110, LUI 1111.
- Per-instruction sequences. Each entry lists step1 and then step2 if present. `aluout_load` is 1 on every step except the branch compare step.
  - R-type (opcode 0x00), add 0x20: ADD.
  - R-type, sub 0x22: SUB.
  - R-type, and 0x24: AND.
  - R-type, sll 0x00: SHIFT_L1, SHIFT_L2.
  - R-type, srl 0x02: SHIFT_R, SHIFT_R.
  - R-type, sra 0x03: SHIFT_RA1, SHIFT_RA2.
  - addi 0x08, addiu 0x09, lw 0x23, sw 0x2B: ADD.
  - slti 0x0A: SLTI.
  - lui 0x0F: LUI.
  - beq 0x04, bne 0x05, ble 0x06, bgt 0x07: ADD (target, load=1), then BEQ/BNE/BLE/BGT (compare, load=0, so the target is preserved).
  - Any other opcode or funct: no steps; `illegal`=1.
- FSM states:
  - IDLE: `ready`=1, `alu_op`=NO_OP. On `start`=1, latch the sequence and go to STEP1; an unsupported code goes straight to DONE with the illegal flag set.
  - STEP1: issue step1. Go to STEP2 if the sequence has two steps, else DONE.
  - STEP2: issue step2, then go to DONE.
  - DONE: `alu_op`=NO_OP, `done`=1, `illegal`=latched flag. Unconditionally return to IDLE.
- `start` while `ready`=0 is ignored; it is not queued.
- Changes on `opcode`/`funct` after acceptance have no effect.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `alu_op`=0000, `ready`=1, `aluout_load`=0, `done`=0, `illegal`=0, latched sequence cleared.
- Reset during any state overrides everything. On the next cycle the block is in IDLE, with no `done` for the aborted instruction.
- All outputs are registered; they change only on `clk` rising edges.
- Accepting edge k (`start`=1, `ready`=1): `ready` drops in cycle k+1.
- One-step instruction: step1 during cycle k+1, `done` during k+2, `ready` again in k+3.
- Two-step instruction: steps during k+1 and k+2, `done` during k+3, `ready` again in k+4.
- Illegal instruction: `done`=`illegal`=1 during k+1, `ready` again in k+2.
- The ALU control decoder registers its outputs, so datapath effects lag `alu_op` by one cycle. `done` is therefore placed one cycle after the last step.
- Back-to-back: `start` held high is next accepted on the first edge with `ready`=1. Minimum spacing is 3 cycles for a one-step instruction.

## Structure
- Shared package `alu_pkg`:
  - ALUOp code constants.
  - Opcode and funct constants.
  - Sequence-length type (0/1/2).
  - FSM state enum.
- The ALU control decoder also imports `alu_pkg`.
- One sub-module, `alu_op_decode`: combinational mapping from (`opcode`, `funct`) to {length, step1 code, step2 code, step1 load, step2 load, illegal}.
- The top level holds the FSM, the latch and the output registers.

## Test plan
- Reset: `reset`=0 for 2 cycles, with `start`=1 and opcode 0x08 → `alu_op`=0000, `ready`=1, no `done`.
- addi: start with opcode 0x08 at edge k → `alu_op`=0001 and `aluout_load`=1 in k+1; `done`=1 and `alu_op`=0000 in k+2.
- sra: opcode 0x00, funct 0x03 → `alu_op` 1000 then 1001 (both load=1), then `done`; `ready` stays 0 for 3 cycles.
- bgt: opcode 0x07 → 0001 (load=1) then 1110 (load=0), then `done`. Toggling `start`/`opcode` mid-sequence changes nothing.
- Illegal: opcode 0x3F → `done`=`illegal`=1 in k+1, `alu_op` stays 0000, `ready`=1 in k+2.
- Reset mid-op: beq accepted, `reset`=0 during STEP2 → next cycle IDLE, `alu_op`=0000, and no `done` ever issued.
